operand_store: RTL and testbench

- Write-back (OS) stage of the Z80 core, at the consumer end of the execute-stage result interface (ie_os_result, ie_os_result_high, ie_os_flag_reg).
- Commits each execute result to one destination: an 8-bit register, a 16-bit register pair, a memory byte, or a memory word.
- Also updates the architectural flag register.
- Started by the control FSM with a one-cycle enable; reports completion back to the FSM with a one-cycle done pulse.

---
 rtl/operand_store.sv | 136 +++++++++++++
 tb/tb_operand_store.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_store.sv
// operand_store: write-back stage of the Z80 core.
// Commits one execute-stage result to an 8-bit register, a 16-bit register pair,
// a memory byte or a little-endian memory word, then optionally commits flags.
// Optional build macro OS_FLAG_MASK_EN adds fsm_os_flag_mask: only the masked
// flag bits are replaced on a flag commit (INC keeps C, for example).
module operand_store #(
  parameter int ADDR_W    = 16,
  parameter int REG_SEL_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fsm_os_en,
  input  logic [1:0]           fsm_os_dest,
  input  logic [REG_SEL_W-1:0] fsm_os_reg_sel,
  input  logic [ADDR_W-1:0]    fsm_os_addr,
  input  logic                 fsm_os_flag_we,
`ifdef OS_FLAG_MASK_EN
  input  logic [7:0]           fsm_os_flag_mask,
`endif
  input  logic [7:0]           ie_os_result,
  input  logic [7:0]           ie_os_result_high,
  input  logic [7:0]           ie_os_flag_reg,
  input  logic                 mem_wait,
  output logic                 os_rf_we,
  output logic                 os_rf_we_high,
  output logic [REG_SEL_W-1:0] os_rf_sel,
  output logic [7:0]           os_rf_data,
  output logic [7:0]           os_rf_data_high,
  output logic                 mem_wr,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [7:0]           mem_wdata,
  output logic [7:0]           os_flag_reg,
  output logic                 os_fsm_done,
  output logic                 os_fsm_busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REG_WR = 3'd1,
    MEM_LO = 3'd2,
    MEM_HI = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [1:0] DEST_REG16 = 2'd1;
  localparam logic [1:0] DEST_MEMW  = 2'd3;

  state_t                 state_q, state_d;
  logic [1:0]             dest_q;
  logic [REG_SEL_W-1:0]   sel_q;
  logic [ADDR_W-1:0]      addr_q;
  logic                   flag_we_q;
  logic [7:0]             lo_q, hi_q, flags_in_q;
  logic [7:0]             flag_q, flag_d;
  logic                   start;

  // A command is only accepted while idle; pulses during a command are dropped.
  assign start = (state_q == IDLE) && fsm_os_en;

`ifdef OS_FLAG_MASK_EN
  logic [7:0] mask_q;

  // Mask is part of the command and captured with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      mask_q <= '0;
    else if (start) mask_q <= fsm_os_flag_mask;
  end

  assign flag_d = (flag_q & ~mask_q) | (flags_in_q & mask_q);
`else
  assign flag_d = flags_in_q;
`endif

  // Control state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: memory states hold until an edge sees mem_wait low.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fsm_os_en) state_d = fsm_os_dest[1] ? MEM_LO : REG_WR;
      REG_WR:  state_d = DONE;
      MEM_LO:  if (!mem_wait) state_d = (dest_q == DEST_MEMW) ? MEM_HI : DONE;
      MEM_HI:  if (!mem_wait) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command capture; inputs are ignored until the next accepted command.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dest_q     <= '0;
      sel_q      <= '0;
      addr_q     <= '0;
      flag_we_q  <= 1'b0;
      lo_q       <= '0;
      hi_q       <= '0;
      flags_in_q <= '0;
    end else if (start) begin
      dest_q     <= fsm_os_dest;
      sel_q      <= fsm_os_reg_sel;
      addr_q     <= fsm_os_addr;
      flag_we_q  <= fsm_os_flag_we;
      lo_q       <= ie_os_result;
      hi_q       <= ie_os_result_high;
      flags_in_q <= ie_os_flag_reg;
    end
  end

  // Flags commit on the edge leaving DONE, i.e. after the data write is over.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               flag_q <= '0;
    else if (state_q == DONE && flag_we_q)   flag_q <= flag_d;
  end

  // Outputs decode from state; data/address follow the captured command so
  // they read zero after reset and hold their last values while idle.
  always_comb begin
    os_rf_we        = (state_q == REG_WR);
    os_rf_we_high   = (state_q == REG_WR) && (dest_q == DEST_REG16);
    os_rf_sel       = sel_q;
    os_rf_data      = lo_q;
    os_rf_data_high = hi_q;
    mem_wr          = (state_q == MEM_LO) || (state_q == MEM_HI);
    mem_addr        = (state_q == MEM_HI) ? addr_q + ADDR_W'(1) : addr_q;
    mem_wdata       = (state_q == MEM_HI) ? hi_q : lo_q;
    os_flag_reg     = flag_q;
    os_fsm_done     = (state_q == DONE);
    os_fsm_busy     = (state_q != IDLE);
  end

endmodule

// File: tb/tb_operand_store.sv
// Self-checking bench for operand_store: directed literal cases plus random
// commands checked every cycle against a transaction-level model.
module tb_operand_store;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  dest = '0;
  logic [3:0]  sel = '0;
  logic [15:0] addr = '0;
  logic        flag_we = 1'b0;
  logic [7:0]  res = '0, resh = '0, flags = '0, mask = '0;
  logic        mem_wait = 1'b0;
  logic        rand_wait = 1'b0;

  logic        os_rf_we, os_rf_we_high, mem_wr, os_fsm_done, os_fsm_busy;
  logic [3:0]  os_rf_sel;
  logic [7:0]  os_rf_data, os_rf_data_high, mem_wdata, os_flag_reg;
  logic [15:0] mem_addr;

  always #5 clk = ~clk;

  operand_store #(.ADDR_W(16), .REG_SEL_W(4)) dut (
    .clk(clk), .reset(reset),
    .fsm_os_en(en), .fsm_os_dest(dest), .fsm_os_reg_sel(sel),
    .fsm_os_addr(addr), .fsm_os_flag_we(flag_we),
`ifdef OS_FLAG_MASK_EN
    .fsm_os_flag_mask(mask),
`endif
    .ie_os_result(res), .ie_os_result_high(resh), .ie_os_flag_reg(flags),
    .mem_wait(mem_wait),
    .os_rf_we(os_rf_we), .os_rf_we_high(os_rf_we_high), .os_rf_sel(os_rf_sel),
    .os_rf_data(os_rf_data), .os_rf_data_high(os_rf_data_high),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .os_flag_reg(os_flag_reg), .os_fsm_done(os_fsm_done), .os_fsm_busy(os_fsm_busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct {
    bit          is_mem;
    bit          hi;
    logic [3:0]  sel;
    logic [15:0] addr;
    logic [7:0]  d;
    logic [7:0]  dh;
  } wr_t;

  wr_t         q[$];
  wr_t         w, got;
  bit          mbusy = 1'b0;
  bit          was_busy, exp_done;
  int          cnt, lat, waits;
  logic [7:0]  mflags = '0;
  logic        pend_we;
  logic [7:0]  pend_f;
`ifdef OS_FLAG_MASK_EN
  logic [7:0]  pend_m;
`endif

  // Single compare process: outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      mbusy  = 1'b0;
      mflags = '0;
      q.delete();
    end else begin
      was_busy = mbusy;
      chk("flag_reg", os_flag_reg, mflags);
      chk("busy", os_fsm_busy, mbusy);
      exp_done = 1'b0;
      if (mbusy) begin
        cnt++;
        exp_done = (cnt == lat + waits);
      end
      chk("done", os_fsm_done, exp_done);
      if (os_rf_we) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL rf_unexpected actual=we expected=no write @%0t", $time);
        end else begin
          got = q.pop_front();
          chk("rf_kind", got.is_mem, 0);
          chk("rf_sel", os_rf_sel, got.sel);
          chk("rf_data", os_rf_data, got.d);
          chk("rf_we_high", os_rf_we_high, got.hi);
          if (got.hi) chk("rf_data_high", os_rf_data_high, got.dh);
        end
      end
      if (mem_wr && !mem_wait) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL mem_unexpected actual=wr expected=no write @%0t", $time);
        end else begin
          got = q.pop_front();
          chk("mem_kind", got.is_mem, 1);
          chk("mem_addr", mem_addr, got.addr);
          chk("mem_wdata", mem_wdata, got.d);
        end
      end
      if (mem_wr && mem_wait) waits++;
      if (mbusy && (exp_done || cnt > lat + waits)) begin
        chk("writes_left", q.size(), 0);
        q.delete();
        if (pend_we) begin
`ifdef OS_FLAG_MASK_EN
          mflags = (mflags & ~pend_m) | (pend_f & pend_m);
`else
          mflags = pend_f;
`endif
        end
        mbusy = 1'b0;
      end
      if (!was_busy && en) begin
        if (dest < 2) begin
          w.is_mem = 1'b0; w.hi = (dest == 2'd1); w.sel = sel;
          w.addr = '0; w.d = res; w.dh = resh;
          q.push_back(w);
        end else begin
          w.is_mem = 1'b1; w.hi = 1'b0; w.sel = '0;
          w.addr = addr; w.d = res; w.dh = '0;
          q.push_back(w);
          if (dest == 2'd3) begin
            w.addr = addr + 16'd1; w.d = resh;
            q.push_back(w);
          end
        end
        lat = (dest == 2'd3) ? 3 : 2;
        cnt = 0; waits = 0; mbusy = 1'b1;
        pend_we = flag_we; pend_f = flags;
`ifdef OS_FLAG_MASK_EN
        pend_m = mask;
`endif
      end
    end
  end

  // Random memory wait when enabled.
  always @(posedge clk) begin
    #1;
    if (rand_wait) mem_wait = ($urandom_range(0, 2) == 0);
  end

  // One-cycle start pulse; fields are scrambled afterwards to prove capture.
  task automatic drive_cmd(input logic [1:0] d, input logic [3:0] s, input logic [15:0] a,
                           input logic fw, input logic [7:0] r, input logic [7:0] rh,
                           input logic [7:0] f, input logic [7:0] m);
    @(posedge clk); #1;
    en = 1'b1; dest = d; sel = s; addr = a; flag_we = fw;
    res = r; resh = rh; flags = f; mask = m;
    @(posedge clk); #1;
    en = 1'b0; dest = 2'($urandom); sel = 4'($urandom); addr = 16'($urandom);
    flag_we = 1'($urandom); res = 8'($urandom); resh = 8'($urandom);
    flags = 8'($urandom); mask = 8'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (os_fsm_busy && n < 60) begin @(negedge clk); n++; end
    if (n >= 60) begin
      checks++; failures++;
      $display("FAIL idle_timeout actual=busy expected=idle @%0t", $time);
    end
  endtask

  int ndone;
  logic [7:0] exp6;

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_flags", os_flag_reg, 8'h00);
    chk("rst_busy", os_fsm_busy, 0);
    chk("rst_done", os_fsm_done, 0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    @(posedge clk); #1 reset = 1'b0;

    // reg8 with flag commit
    drive_cmd(2'd0, 4'd7, 16'h0, 1'b1, 8'd225, 8'h00, 8'h91, 8'hFF);
    @(negedge clk);
    chk("t2_we", os_rf_we, 1); chk("t2_data", os_rf_data, 8'hE1);
    chk("t2_we_high", os_rf_we_high, 0); chk("t2_sel", os_rf_sel, 4'd7);
    @(negedge clk); chk("t2_done", os_fsm_done, 1);
    @(negedge clk); chk("t2_flags", os_flag_reg, 8'h91);
    wait_idle();

    // reg16, no flag commit
    drive_cmd(2'd1, 4'd3, 16'h0, 1'b0, 8'h34, 8'h12, 8'h00, 8'hFF);
    @(negedge clk);
    chk("t3_we", os_rf_we, 1); chk("t3_we_high", os_rf_we_high, 1);
    chk("t3_data", os_rf_data, 8'h34); chk("t3_data_high", os_rf_data_high, 8'h12);
    @(negedge clk); @(negedge clk); chk("t3_flags", os_flag_reg, 8'h91);
    wait_idle();

    // mem word at top of memory, two wait cycles on the low byte
    mem_wait = 1'b1;
    drive_cmd(2'd3, 4'd0, 16'hFFFF, 1'b0, 8'hCD, 8'hAB, 8'h00, 8'h00);
    @(negedge clk);
    chk("t4_lo_wr", mem_wr, 1); chk("t4_lo_addr", mem_addr, 16'hFFFF);
    chk("t4_lo_data", mem_wdata, 8'hCD);
    @(posedge clk); @(posedge clk); #1 mem_wait = 1'b0;
    @(negedge clk); chk("t4_still_lo", mem_addr, 16'hFFFF);
    @(negedge clk);
    chk("t4_hi_wr", mem_wr, 1); chk("t4_hi_addr", mem_addr, 16'h0000);
    chk("t4_hi_data", mem_wdata, 8'hAB);
    @(negedge clk); chk("t4_done", os_fsm_done, 1);
    wait_idle();

    // start pulse during MEM_HI is ignored
    drive_cmd(2'd3, 4'd0, 16'h1230, 1'b0, 8'h11, 8'h22, 8'h00, 8'h00);
    @(negedge clk); chk("t5_lo_addr", mem_addr, 16'h1230);
    @(posedge clk); #1;
    en = 1'b1; dest = 2'd0; sel = 4'd9; res = 8'h5A;
    @(posedge clk); #1 en = 1'b0;
    ndone = 0;
    repeat (6) begin @(negedge clk); if (os_fsm_done) ndone++; end
    chk("t5_one_done", ndone, 1);
    wait_idle();

    // flag mask
    drive_cmd(2'd0, 4'd1, 16'h0, 1'b1, 8'h00, 8'h00, 8'h01, 8'hFF);
    wait_idle();
    drive_cmd(2'd0, 4'd1, 16'h0, 1'b1, 8'h00, 8'h00, 8'h50, 8'hFE);
    wait_idle();
`ifdef OS_FLAG_MASK_EN
    exp6 = 8'h51;
`else
    exp6 = 8'h50;
`endif
    chk("t6_flags", os_flag_reg, exp6);

    // reset in the middle of a stalled memory write
    mem_wait = 1'b1;
    drive_cmd(2'd2, 4'd0, 16'h4242, 1'b1, 8'h77, 8'h00, 8'hEE, 8'hFF);
    @(negedge clk); chk("t1_wr_before", mem_wr, 1);
    #2 reset = 1'b1;
    #1;
    chk("t1_mem_wr", mem_wr, 0); chk("t1_busy", os_fsm_busy, 0);
    chk("t1_flags", os_flag_reg, 8'h00); chk("t1_done", os_fsm_done, 0);
    chk("t1_addr", mem_addr, 16'h0000);
    ndone = 0;
    repeat (3) begin @(negedge clk); if (os_fsm_done) ndone++; end
    chk("t1_no_done", ndone, 0);
    @(posedge clk); #1 reset = 1'b0; mem_wait = 1'b0;

    // randomized commands with random waits and stray start pulses
    rand_wait = 1'b1;
    for (int i = 0; i < 300; i++) begin
      int n;
      drive_cmd(2'($urandom), 4'($urandom),
                ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom),
                1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      n = 0;
      while (os_fsm_busy && n < 60) begin
        @(posedge clk); #1;
        en = os_fsm_busy && ($urandom_range(0, 9) == 0);
        dest = 2'($urandom); sel = 4'($urandom); res = 8'($urandom);
        n++;
      end
      en = 1'b0;
      if (n >= 60) begin
        checks++; failures++;
        $display("FAIL rand_timeout actual=busy expected=idle @%0t", $time);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    rand_wait = 1'b0;
    mem_wait = 1'b0;
    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
